univ_shiftreg: RTL and testbench
================================

// Module: univ_shiftreg
// PURPOSE
//   Parametrised universal shift register; next generation of the 4-bit serial-in shift register.
//   Mode-selectable operations:
//     - hold, logical shift left/right, rotate left/right, arithmetic shift right
//     - parallel load, synchronous clear
//   A shift counter raises a one-cycle DONE pulse after every N shift/rotate operations.
//   Used as a serializer/deserializer and general data-path shifter in lab designs.
// PARAMETERS
//   N          4     register width in bits; legal range N >= 2
//   RESET_VAL  0     N-bit value loaded into Q on reset
// PORTS
//   CLK     in   1               rising-edge clock
//   RST_N   in   1               asynchronous active-low reset
//   EN      in   1               operation enable; 0 = hold everything
//   MODE    in   3               operation select (see BEHAVIOUR)
//   SIN_L   in   1               serial input entering Q[N-1] on shift right
//   SIN_R   in   1               serial input entering Q[0] on shift left
//   D       in   N               parallel load data
//   Q       out  N               register contents
//   SOUT_L  out  1               = Q[N-1], combinational
//   SOUT_R  out  1               = Q[0], combinational
//   CNT     out  $clog2(N+1)     shifts completed since last load/clear/wrap
//   DONE    out  1               one-cycle pulse when the N-th shift completes
// BEHAVIOUR
//   Reset
//     - RST_N low: immediately Q=RESET_VAL, CNT=0, DONE=0, independent of CLK.
//     - Deassertion takes effect at the next rising CLK edge.
//     - Reset mid-sequence discards the partial count.
//   Enable
//     - All state updates on the rising CLK edge, only when EN=1.
//     - EN=0: Q and CNT hold; DONE=0.
//   MODE encoding (EN=1)
//     000 hold                 Q unchanged
//     001 shift left           Q <= {Q[N-2:0], SIN_R}
//     010 shift right          Q <= {SIN_L, Q[N-1:1]}
//     011 rotate left          Q <= {Q[N-2:0], Q[N-1]}
//     100 rotate right         Q <= {Q[0], Q[N-1:1]}
//     101 parallel load        Q <= D
//     110 arith shift right    Q <= {Q[N-1], Q[N-1:1]}
//     111 clear                Q <= 0
//   Shift counter
//     - Modes 001/010/011/100/110 are "shift ops".
//     - Each shift op: CNT <= CNT+1.
//     - If CNT==N-1 before the op: CNT <= 0 and DONE=1 for exactly the following cycle.
//     - Modes 101/111: CNT <= 0, DONE=0; no DONE even if CNT was N-1.
//     - Mode 000: CNT holds, DONE=0.
//     - DONE is registered and high only in the cycle after the N-th shift edge.
//     - Mixed shift directions all count; CNT never reaches N.
//   Latency: Q, CNT and DONE are valid one edge after the sampled inputs; SOUT_L/SOUT_R follow Q with zero latency.
//   Mode changes may occur on any cycle; there is no internal pipeline and no illegal MODE value.
// TESTING (N=4, RESET_VAL=0)
//   1. RST_N=0 mid-run with Q=1011, CNT=2
//        -> Q=0000, CNT=0, DONE=0 before the next CLK edge.
//   2. Load D=1001 (MODE=101), then 4x shift left with SIN_R=1
//        -> Q: 0011, 0111, 1111, 1111
//        -> SOUT_L sequence 1,0,0,1,1
//        -> DONE high only in the cycle after the 4th shift; CNT 1,2,3,0.
//   3. Load 1000, arith shift right x2
//        -> Q: 1100, 1110
//      Load 0100, shift right with SIN_L=0
//        -> Q: 0010
//   4. Load 1001, rotate left -> 0011; rotate right -> 1001; CNT=2
//      Then EN=0 for 3 cycles with MODE=001 -> Q and CNT unchanged, DONE=0.
//   5. 3 shifts (CNT=3), then MODE=111
//        -> Q=0000, CNT=0, DONE never asserted
//      Then 4 shifts -> DONE pulses once.
//   6. Serialize D=0110 by 4 right shifts, feeding SOUT_R into SIN_L of a second instance
//        -> second instance Q=0110 at the DONE cycle.

Source files
------------

// File: rtl/univ_shiftreg.sv
// Parametrised universal shift register: hold/shift/rotate/arith-shift/load/clear,
// with a shift counter that pulses DONE after every N shift operations.
module univ_shiftreg #(
   parameter int             N         = 4,
   parameter logic [N-1:0]   RESET_VAL = '0
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      EN,
   input  logic [2:0]                MODE,
   input  logic                      SIN_L,
   input  logic                      SIN_R,
   input  logic [N-1:0]              D,
   output logic [N-1:0]              Q,
   output logic                      SOUT_L,
   output logic                      SOUT_R,
   output logic [$clog2(N+1)-1:0]    CNT,
   output logic                      DONE
);

   localparam int               CW       = $clog2(N+1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(N-1);

   typedef enum logic [2:0] {
      M_HOLD  = 3'b000,
      M_SHL   = 3'b001,
      M_SHR   = 3'b010,
      M_ROL   = 3'b011,
      M_ROR   = 3'b100,
      M_LOAD  = 3'b101,
      M_ASR   = 3'b110,
      M_CLEAR = 3'b111
   } mode_t;

   logic [N-1:0]  r_q;
   logic [CW-1:0] r_cnt;
   logic          r_done;

   logic [N-1:0]  w_q_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_done_nxt;
   logic          w_shift_op;

   always_comb begin
      w_q_nxt    = r_q;
      w_shift_op = 1'b0;
      unique case (mode_t'(MODE))
         M_HOLD:  w_q_nxt = r_q;
         M_SHL:   begin w_q_nxt = {r_q[N-2:0], SIN_R};    w_shift_op = 1'b1; end
         M_SHR:   begin w_q_nxt = {SIN_L, r_q[N-1:1]};    w_shift_op = 1'b1; end
         M_ROL:   begin w_q_nxt = {r_q[N-2:0], r_q[N-1]}; w_shift_op = 1'b1; end
         M_ROR:   begin w_q_nxt = {r_q[0], r_q[N-1:1]};   w_shift_op = 1'b1; end
         M_LOAD:  w_q_nxt = D;
         M_ASR:   begin w_q_nxt = {r_q[N-1], r_q[N-1:1]}; w_shift_op = 1'b1; end
         M_CLEAR: w_q_nxt = '0;
         default: w_q_nxt = r_q;
      endcase
   end

   // Counter wraps to zero on the N-th shift; load and clear restart it without a pulse.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_done_nxt = 1'b0;
      if (w_shift_op) begin
         if (r_cnt == CNT_LAST) begin
            w_cnt_nxt  = '0;
            w_done_nxt = 1'b1;
         end else begin
            w_cnt_nxt  = r_cnt + CW'(1);
         end
      end else if (MODE == M_LOAD || MODE == M_CLEAR) begin
         w_cnt_nxt = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_q    <= RESET_VAL;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (EN) begin
         r_q    <= w_q_nxt;
         r_cnt  <= w_cnt_nxt;
         r_done <= w_done_nxt;
      end else begin
         r_done <= 1'b0;
      end
   end

   assign Q      = r_q;
   assign SOUT_L = r_q[N-1];
   assign SOUT_R = r_q[0];
   assign CNT    = r_cnt;
   assign DONE   = r_done;

endmodule

// File: tb/tb_univ_shiftreg.sv
// Bench for univ_shiftreg: directed scenarios plus randomized operations compared
// against an arithmetic reference model of the register and its shift counter.
module tb_univ_shiftreg;

   localparam int N    = 4;
   localparam int CW   = $clog2(N+1);
   localparam int MASK = (1 << N) - 1;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          EN;
   logic [2:0]    MODE;
   logic          SIN_L, SIN_R;
   logic [N-1:0]  D;
   logic [N-1:0]  Q;
   logic          SOUT_L, SOUT_R;
   logic [CW-1:0] CNT;
   logic          DONE;

   logic          EN2;
   logic [2:0]    MODE2;
   logic [N-1:0]  Q2;
   logic          SOUT_L2, SOUT_R2;
   logic [CW-1:0] CNT2;
   logic          DONE2;

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned m_q;
   int unsigned m_cnt;
   int unsigned m_done;

   always #5 CLK = ~CLK;

   univ_shiftreg #(.N(N), .RESET_VAL('0)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .SIN_L(SIN_L), .SIN_R(SIN_R),
      .D(D), .Q(Q), .SOUT_L(SOUT_L), .SOUT_R(SOUT_R), .CNT(CNT), .DONE(DONE)
   );

   // Deserializer fed from the first instance's serial output.
   univ_shiftreg #(.N(N), .RESET_VAL('0)) u_des (
      .CLK(CLK), .RST_N(RST_N), .EN(EN2), .MODE(MODE2), .SIN_L(SOUT_R), .SIN_R(1'b0),
      .D('0), .Q(Q2), .SOUT_L(SOUT_L2), .SOUT_R(SOUT_R2), .CNT(CNT2), .DONE(DONE2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_q"},    32'(Q),      m_q);
      chk({tag, "_cnt"},  32'(CNT),    m_cnt);
      chk({tag, "_done"}, 32'(DONE),   m_done);
      chk({tag, "_soL"},  32'(SOUT_L), (m_q >> (N-1)) & 1);
      chk({tag, "_soR"},  32'(SOUT_R), m_q & 1);
   endtask

   function automatic void model_edge(input bit en, input int unsigned mode,
                                      input bit sl, input bit sr, input int unsigned d);
      bit shift;
      shift  = en && (mode == 1 || mode == 2 || mode == 3 || mode == 4 || mode == 6);
      m_done = (shift && m_cnt == N-1) ? 1 : 0;
      if (en) begin
         case (mode)
            1: m_q = ((m_q << 1) | sr) & MASK;
            2: m_q = (m_q >> 1) | (int'(sl) << (N-1));
            3: m_q = ((m_q << 1) | (m_q >> (N-1))) & MASK;
            4: m_q = (m_q >> 1) | ((m_q & 1) << (N-1));
            5: m_q = d & MASK;
            6: m_q = (m_q >> 1) | (m_q & (1 << (N-1)));
            7: m_q = 0;
            default: ;
         endcase
      end
      if (shift)                              m_cnt = (m_cnt + 1) % N;
      else if (en && (mode == 5 || mode == 7)) m_cnt = 0;
   endfunction

   task automatic step(input bit en, input logic [2:0] mode, input bit sl, input bit sr,
                       input logic [N-1:0] d);
      @(negedge CLK);
      EN = en; MODE = mode; SIN_L = sl; SIN_R = sr; D = d;
      @(posedge CLK);
      model_edge(en, mode, sl, sr, d);
      #1;
      chk_model("step");
   endtask

   // Asynchronous reset asserted mid-cycle, checked before the next rising edge.
   task automatic async_reset();
      @(negedge CLK);
      EN = 1'b0;
      #2 RST_N = 1'b0;
      m_q = 0; m_cnt = 0; m_done = 0;
      #1;
      chk_model("rst");
      #1 RST_N = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0; EN = 1'b0; MODE = '0; SIN_L = 1'b0; SIN_R = 1'b0; D = '0;
      EN2 = 1'b0; MODE2 = '0;
      m_q = 0; m_cnt = 0; m_done = 0;
      #12;
      chk_model("reset_init");
      @(negedge CLK) RST_N = 1'b1;

      // Q=1011, CNT=2 via load 1110 and two right rotations, then reset mid-run
      step(1, 3'b101, 0, 0, 4'b1110);
      step(1, 3'b100, 0, 0, '0);
      step(1, 3'b100, 0, 0, '0);
      chk("t1_pre_q", 32'(Q), 32'b1011);
      chk("t1_pre_cnt", 32'(CNT), 2);
      async_reset();
      chk("t1_q", 32'(Q), 0);
      chk("t1_cnt", 32'(CNT), 0);

      // Load 1001 then four left shifts with SIN_R=1
      step(1, 3'b101, 0, 0, 4'b1001);
      chk("t2_soL0", 32'(SOUT_L), 1);
      step(1, 3'b001, 0, 1, '0); chk("t2_q1", 32'(Q), 32'b0011); chk("t2_d1", 32'(DONE), 0);
      step(1, 3'b001, 0, 1, '0); chk("t2_q2", 32'(Q), 32'b0111); chk("t2_c2", 32'(CNT), 2);
      step(1, 3'b001, 0, 1, '0); chk("t2_q3", 32'(Q), 32'b1111); chk("t2_d3", 32'(DONE), 0);
      step(1, 3'b001, 0, 1, '0); chk("t2_q4", 32'(Q), 32'b1111); chk("t2_d4", 32'(DONE), 1);
      chk("t2_c4", 32'(CNT), 0);
      step(1, 3'b000, 0, 0, '0); chk("t2_d5", 32'(DONE), 0);

      // Arithmetic and logical right shifts
      step(1, 3'b101, 0, 0, 4'b1000);
      step(1, 3'b110, 1, 0, '0); chk("t3_asr1", 32'(Q), 32'b1100);
      step(1, 3'b110, 1, 0, '0); chk("t3_asr2", 32'(Q), 32'b1110);
      step(1, 3'b101, 0, 0, 4'b0100);
      step(1, 3'b010, 0, 0, '0); chk("t3_shr", 32'(Q), 32'b0010);

      // Rotates, then EN=0 hold with a shift mode presented
      step(1, 3'b101, 0, 0, 4'b1001);
      step(1, 3'b011, 0, 0, '0); chk("t4_rol", 32'(Q), 32'b0011);
      step(1, 3'b100, 0, 0, '0); chk("t4_ror", 32'(Q), 32'b1001);
      chk("t4_cnt", 32'(CNT), 2);
      for (int i = 0; i < 3; i++) step(0, 3'b001, 1, 1, '0);
      chk("t4_hold_q", 32'(Q), 32'b1001);
      chk("t4_hold_cnt", 32'(CNT), 2);

      // Clear at CNT=N-1 gives no DONE; then a full run of N shifts does
      step(1, 3'b111, 0, 0, '0);
      for (int i = 0; i < 3; i++) step(1, 3'b001, 0, 1, '0);
      chk("t5_cnt3", 32'(CNT), 3);
      step(1, 3'b111, 0, 0, '0);
      chk("t5_clr_q", 32'(Q), 0);
      chk("t5_clr_done", 32'(DONE), 0);
      for (int i = 0; i < 4; i++) step(1, 3'b010, 0, 0, '0);
      chk("t5_done", 32'(DONE), 1);

      // Serialize 0110 LSB-first into the second instance
      EN2 = 1'b1; MODE2 = 3'b111;
      step(1, 3'b101, 0, 0, 4'b0110);
      MODE2 = 3'b010;
      for (int i = 0; i < 4; i++) step(1, 3'b010, 0, 0, '0);
      chk("t6_done", 32'(DONE), 1);
      chk("t6_des_q", 32'(Q2), 32'b0110);
      chk("t6_des_done", 32'(DONE2), 1);
      EN2 = 1'b0; MODE2 = 3'b000;

      // Randomized operations with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            async_reset();
         end else begin
            step(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
